// File: rtl/fetch_sequencer.sv
// fetch_sequencer: 6502 front end that loads PC from the reset vector, fetches opcode plus 0-2 operands, and issues to execute.
// Build option FETCH_SEQ_ILLEGAL_TRAP_EN: an unrecognised opcode halts the sequencer until reset instead of issuing as 1 byte.
module fetch_sequencer #(
    parameter int          ADDR_WIDTH   = 16,
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [7:0]            read_data,
    input  logic                  ready,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  rd_en,
    output logic [7:0]            opcode,
    output logic [7:0]            oper_lo,
    output logic [7:0]            oper_hi,
    output logic [1:0]            instr_len,
    output logic                  instr_valid,
    input  logic                  exec_done,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    output logic                  illegal,
    output logic [7:0]            debug_state,
    output logic [ADDR_WIDTH-1:0] debug_PC
);
    typedef enum logic [7:0] {
        RESET  = 8'h01,
        VEC_LO = 8'h02,
        VEC_HI = 8'h04,
        FETCH  = 8'h08,
        OPER1  = 8'h10,
        OPER2  = 8'h20,
        ISSUE  = 8'h40,
        HALT   = 8'h80
    } state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] pc, pc_nx;
    logic [7:0]            opcode_nx, oper_lo_nx, oper_hi_nx;
    logic [1:0]            len_nx, dec_len;
    logic                  illegal_nx;

    // Instruction length by opcode; 0 marks an unrecognised opcode.
    function automatic logic [1:0] decode_len(input logic [7:0] op);
        case (op)
            8'hEA, 8'hE8, 8'hCA, 8'hAA, 8'h60:        decode_len = 2'd1;
            8'hA9, 8'hA2, 8'hA5, 8'h85, 8'hD0, 8'hF0: decode_len = 2'd2;
            8'h4C, 8'h6C, 8'h20, 8'hAD, 8'h8D:        decode_len = 2'd3;
            default:                                  decode_len = 2'd0;
        endcase
    endfunction

    assign dec_len     = decode_len(read_data);
    assign debug_state = state;
    assign debug_PC    = pc;

    // State, PC and instruction registers; reset clears everything and abandons any read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= RESET;
            pc        <= '0;
            opcode    <= 8'h00;
            oper_lo   <= 8'h00;
            oper_hi   <= 8'h00;
            instr_len <= 2'd0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            opcode    <= opcode_nx;
            oper_lo   <= oper_lo_nx;
            oper_hi   <= oper_hi_nx;
            instr_len <= len_nx;
            illegal   <= illegal_nx;
        end
    end

    // Next state, register updates and memory/handshake outputs; nothing advances while ready is low.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        opcode_nx   = opcode;
        oper_lo_nx  = oper_lo;
        oper_hi_nx  = oper_hi;
        len_nx      = instr_len;
`ifdef FETCH_SEQ_ILLEGAL_TRAP_EN
        illegal_nx  = illegal;
`else
        illegal_nx  = 1'b0;
`endif
        rd_en       = 1'b0;
        address     = '0;
        instr_valid = 1'b0;
        case (state)
            RESET: state_nx = VEC_LO;
            VEC_LO: begin
                rd_en   = 1'b1;
                address = ADDR_WIDTH'(RESET_VECTOR);
                if (ready) begin
                    pc_nx    = ADDR_WIDTH'({pc[15:8], read_data});
                    state_nx = VEC_HI;
                end
            end
            VEC_HI: begin
                rd_en   = 1'b1;
                address = ADDR_WIDTH'(RESET_VECTOR + 16'd1);
                if (ready) begin
                    pc_nx    = ADDR_WIDTH'({read_data, pc[7:0]});
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                rd_en   = 1'b1;
                address = pc;
                if (ready) begin
                    opcode_nx  = read_data;
                    pc_nx      = pc + ADDR_WIDTH'(1);
                    oper_lo_nx = 8'h00;
                    oper_hi_nx = 8'h00;
                    len_nx     = (dec_len == 2'd0) ? 2'd1 : dec_len;
                    illegal_nx = (dec_len == 2'd0);
`ifdef FETCH_SEQ_ILLEGAL_TRAP_EN
                    state_nx   = (dec_len == 2'd0) ? HALT : (dec_len == 2'd1) ? ISSUE : OPER1;
`else
                    state_nx   = (dec_len > 2'd1) ? OPER1 : ISSUE;
`endif
                end
            end
            OPER1: begin
                rd_en   = 1'b1;
                address = pc;
                if (ready) begin
                    oper_lo_nx = read_data;
                    pc_nx      = pc + ADDR_WIDTH'(1);
                    state_nx   = (instr_len == 2'd3) ? OPER2 : ISSUE;
                end
            end
            OPER2: begin
                rd_en   = 1'b1;
                address = pc;
                if (ready) begin
                    oper_hi_nx = read_data;
                    pc_nx      = pc + ADDR_WIDTH'(1);
                    state_nx   = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (exec_done) begin
                    pc_nx    = pc_load ? pc_load_value : pc;
                    state_nx = FETCH;
                end
            end
            default: state_nx = state;
        endcase
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random and directed stimulus with an instruction-level reference model feeding a scoreboard.
module tb_fetch_sequencer;
    logic        clk = 1'b0, resetn = 1'b0, ready = 1'b0, exec_done = 1'b0, pc_load = 1'b0;
    logic [15:0] pc_load_value = 16'h0000;
    logic [7:0]  read_data, opcode, oper_lo, oper_hi, debug_state;
    logic [15:0] address, debug_PC;
    logic [1:0]  instr_len;
    logic        rd_en, instr_valid, illegal;

    logic [7:0] mem [65536];
    assign read_data = mem[address];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .resetn(resetn), .read_data(read_data), .ready(ready),
        .address(address), .rd_en(rd_en), .opcode(opcode), .oper_lo(oper_lo),
        .oper_hi(oper_hi), .instr_len(instr_len), .instr_valid(instr_valid),
        .exec_done(exec_done), .pc_load(pc_load), .pc_load_value(pc_load_value),
        .illegal(illegal), .debug_state(debug_state), .debug_PC(debug_PC)
    );

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [1:0]  len;
        logic [15:0] pc_after;
        logic        ill;
    } ins_t;

    int errors = 0, checks = 0;
    int cyc = 0, rel_cyc = 0;
    int rises[$];
    logic [15:0] exp_addr[$];
    ins_t exp_ins[$];
    ins_t cur, mcur;
    int skip = 1, reads_left = 0, wait_cnt = 0, stall_cnt = 0;
    bit exp_vld = 0, new_vld = 0, st = 0, pv = 0;
    bit drv_en = 0, mon_en = 0, noise = 0, jmp_follow = 0;
    int rdy_pct = 100, fixed_delay = 0, load_pct = 0;
`ifdef FETCH_SEQ_ILLEGAL_TRAP_EN
    bit allow_ill = 0;
`else
    bit allow_ill = 1;
`endif
    logic [7:0] legal [16] = '{8'hEA, 8'hE8, 8'hCA, 8'hAA, 8'h60, 8'hA9, 8'hA2, 8'hA5,
                               8'h85, 8'hD0, 8'hF0, 8'h4C, 8'h6C, 8'h20, 8'hAD, 8'h8D};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_len(input logic [7:0] op);
        if (op inside {8'hEA, 8'hE8, 8'hCA, 8'hAA, 8'h60}) return 2'd1;
        if (op inside {8'hA9, 8'hA2, 8'hA5, 8'h85, 8'hD0, 8'hF0}) return 2'd2;
        if (op inside {8'h4C, 8'h6C, 8'h20, 8'hAD, 8'h8D}) return 2'd3;
        return 2'd0;
    endfunction

    // Expected instruction at pc: its bytes come straight from memory, its reads are queued in order.
    function automatic void push_instr(input logic [15:0] pc);
        ins_t r;
        logic [1:0] l;
        l = ref_len(mem[pc]);
        r.ill = (l == 2'd0);
        r.len = r.ill ? 2'd1 : l;
        r.op = mem[pc];
        r.lo = (r.len > 2'd1) ? mem[pc + 16'd1] : 8'h00;
        r.hi = (r.len > 2'd2) ? mem[pc + 16'd2] : 8'h00;
        r.pc_after = pc + 16'(r.len);
        for (int i = 0; i < int'(r.len); i++) exp_addr.push_back(pc + 16'(i));
        exp_ins.push_back(r);
        cur = r;
    endfunction

    function automatic void model_reset();
        exp_addr.delete();
        exp_ins.delete();
        exp_addr.push_back(16'hFFFC);
        exp_addr.push_back(16'hFFFD);
        push_instr({mem[16'hFFFD], mem[16'hFFFC]});
        skip = 1;
        reads_left = 2 + int'(cur.len);
        exp_vld = 0;
        wait_cnt = 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Driver: advances the model on each edge from the inputs it applied, then picks the next inputs.
    initial forever begin
        @(posedge clk);
        new_vld = 0;
        if (!resetn) model_reset();
        else if (drv_en) begin
            if (skip > 0) skip--;
            else if (reads_left > 0) begin
                if (ready) begin
                    reads_left--;
                    if (reads_left == 0) begin
                        exp_vld = 1;
                        new_vld = 1;
                    end
                end
            end else if (exp_vld && exec_done) begin
                exp_vld = 0;
                push_instr(pc_load ? pc_load_value : cur.pc_after);
                reads_left = int'(cur.len);
            end
        end
        #1;
        if (drv_en) begin
            int pick;
            st = stall_cnt > 0 && skip == 0 && reads_left == 1 && cur.len == 2'd2 && !exp_vld;
            ready = st ? 1'b0 : ($urandom_range(99) < rdy_pct);
            if (st) stall_cnt--;
            if (exp_vld) begin
                if (new_vld) wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(3));
                exec_done = (wait_cnt == 0);
                if (wait_cnt > 0) wait_cnt--;
            end else exec_done = noise ? 1'($urandom_range(1)) : 1'b0;
            pick = int'($urandom_range(3));
            pc_load = jmp_follow ? (cur.op == 8'h4C) : ($urandom_range(99) < load_pct);
            pc_load_value = jmp_follow ? {cur.hi, cur.lo} :
                            (pick == 0) ? 16'hFFFE : (pick == 1) ? 16'hFFFF : 16'($urandom);
        end
    end

    // Monitor: compares reads and issued instructions against the scoreboard queues.
    always @(negedge clk) begin
        if (!resetn || !mon_en) pv = 0;
        else begin
            chk("instr_valid", instr_valid, exp_vld);
            chk("rd_en", rd_en, skip == 0 && reads_left > 0);
            if (rd_en) begin
                chk("read_pending", exp_addr.size() > 0, 1);
                if (exp_addr.size() > 0) begin
                    chk("address", address, exp_addr[0]);
                    if (ready) void'(exp_addr.pop_front());
                end
            end
            if (instr_valid && !pv) begin
                rises.push_back(cyc);
                chk("issue_pending", exp_ins.size() > 0, 1);
                if (exp_ins.size() > 0) begin
                    mcur = exp_ins.pop_front();
                    chk("opcode", opcode, mcur.op);
                    chk("oper_lo", oper_lo, mcur.lo);
                    chk("oper_hi", oper_hi, mcur.hi);
                    chk("instr_len", instr_len, mcur.len);
                    chk("pc_after", debug_PC, mcur.pc_after);
                    chk("illegal", illegal, mcur.ill);
                end
            end else if (instr_valid) begin
                chk("opcode_hold", opcode, mcur.op);
                chk("oper_lo_hold", oper_lo, mcur.lo);
                chk("oper_hi_hold", oper_hi, mcur.hi);
                chk("illegal_hold", illegal, 0);
            end
            pv = instr_valid;
        end
    end

    task automatic restart();
        drv_en = 0;
        mon_en = 0;
        resetn = 0;
        ready = 0;
        exec_done = 0;
        pc_load = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rises.delete();
        drv_en = 1;
        mon_en = 1;
        resetn = 1;
        rel_cyc = cyc;
    endtask

    task automatic manual_release();
        drv_en = 0;
        mon_en = 0;
        resetn = 0;
        ready = 1;
        exec_done = 0;
        pc_load = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic check_rise(input int idx, input int exp);
        int d;
        d = -1;
        if (rises.size() > idx) d = (idx == 0) ? rises[0] - rel_cyc : rises[idx] - rises[idx-1];
        chk($sformatf("rise_gap%0d", idx), d, exp);
    endtask

    function automatic void fill_nop();
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    endfunction

    initial begin
        int g1[6] = '{4, 2, 2, 4, 3, 2};
        fill_nop();
        @(negedge clk);
        chk("rst_state", debug_state, 8'h01);
        chk("rst_pc", debug_PC, 16'h0000);
        chk("rst_address", address, 16'h0000);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_opcode", opcode, 8'h00);
        chk("rst_len", instr_len, 2'd0);
        chk("rst_illegal", illegal, 0);

        // Vector load, NOP stream, then a JMP redirected to 1234 with exec_done held high.
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'h8003] = 8'h4C; mem[16'h8004] = 8'h34; mem[16'h8005] = 8'h12;
        mem[16'h1234] = 8'hA9; mem[16'h1235] = 8'h55;
        rdy_pct = 100; fixed_delay = 0; jmp_follow = 1; noise = 0; load_pct = 0;
        restart();
        repeat (3) @(posedge clk);
        #1;
        chk("vec_pc", debug_PC, 16'h8000);
        chk("vec_state", debug_state, 8'h08);
        chk("first_fetch", address, 16'h8000);
        repeat (20) @(posedge clk);
        foreach (g1[i]) check_rise(i, g1[i]);

        // Three wait states in OPER1 of A9 55.
        fill_nop();
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h55;
        jmp_follow = 0; stall_cnt = 3;
        restart();
        repeat (5) @(posedge clk);
        #1;
        chk("stall_pc", debug_PC, 16'h8001);
        repeat (9) @(posedge clk);
        chk("stall_used", stall_cnt, 0);
        check_rise(0, 8);
        check_rise(1, 2);

        // PC wrap at FFFF with exec_done delayed 5 cycles.
        fill_nop();
        mem[16'hFFFC] = 8'hFF; mem[16'hFFFD] = 8'hFF;
        fixed_delay = 5;
        restart();
        repeat (20) @(posedge clk);
        check_rise(0, 4);
        check_rise(1, 7);

        // Random memory, wait states, handshake delays and redirects.
        for (int i = 0; i < 65536; i++)
            mem[i] = (allow_ill && $urandom_range(15) == 0) ? 8'($urandom) : legal[$urandom_range(15)];
        rdy_pct = 70; fixed_delay = -1; load_pct = 25; noise = 1;
        restart();
        repeat (3000) @(posedge clk);
        chk("random_progress", rises.size() > 100, 1);

        // Illegal opcode 02.
        fill_nop();
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80; mem[16'h8000] = 8'h02;
        manual_release();
        repeat (4) @(posedge clk);
        #1;
`ifdef FETCH_SEQ_ILLEGAL_TRAP_EN
        chk("trap_illegal", illegal, 1);
        chk("trap_state", debug_state, 8'h80);
        chk("trap_rd_en", rd_en, 0);
        chk("trap_valid", instr_valid, 0);
        exec_done = 1; pc_load = 1; pc_load_value = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        chk("halt_state", debug_state, 8'h80);
        chk("halt_rd_en", rd_en, 0);
        chk("halt_pc", debug_PC, 16'h8001);
        chk("halt_illegal", illegal, 1);
        exec_done = 0; pc_load = 0;
`else
        chk("ill_pulse", illegal, 1);
        chk("ill_valid", instr_valid, 1);
        chk("ill_opcode", opcode, 8'h02);
        chk("ill_len", instr_len, 2'd1);
        chk("ill_pc", debug_PC, 16'h8001);
        @(posedge clk);
        #1;
        chk("ill_pulse_end", illegal, 0);
        chk("ill_valid_hold", instr_valid, 1);
        exec_done = 1;
        @(posedge clk);
        #1;
        exec_done = 0;
        chk("ill_next_fetch", address, 16'h8001);
        chk("ill_next_state", debug_state, 8'h08);
`endif

        // Reset asserted during OPER2 of a JMP.
        mem[16'h8000] = 8'h4C; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
        manual_release();
        repeat (5) @(posedge clk);
        #1;
        chk("oper2_state", debug_state, 8'h20);
        chk("oper2_address", address, 16'h8002);
        resetn = 0;
        #1;
        chk("async_state", debug_state, 8'h01);
        chk("async_address", address, 16'h0000);
        chk("async_rd_en", rd_en, 0);
        chk("async_opcode", opcode, 8'h00);
        chk("async_oper_lo", oper_lo, 8'h00);
        chk("async_len", instr_len, 2'd0);
        chk("async_pc", debug_PC, 16'h0000);
        chk("async_valid", instr_valid, 0);
        chk("async_illegal", illegal, 0);
        @(negedge clk);
        resetn = 1;
        @(posedge clk);
        #1;
        chk("restart_state", debug_state, 8'h02);
        chk("restart_address", address, 16'hFFFC);
        chk("restart_rd_en", rd_en, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Parametrised instruction front end for the 6502 core. It loads PC from the reset vector, then for each instruction fetches the opcode and its 0–2 operand bytes, with memory wait states. It presents the assembled instruction to the execute unit through a valid/done handshake and accepts a PC redirect on completion. It sits between the memory port and the execute/ALU block, replacing the fixed single-mode fetch FSM.

## Interface
- ADDR_WIDTH, 16: address/PC width, 16..24; bits above 15 reset to 0 and are cleared by the vector load.
- RESET_VECTOR, 16'hFFFC: address of the vector low byte; the high byte is at RESET_VECTOR+1.
- clk  in  1  core clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- read_data  in  8  memory read data; valid on any edge where rd_en && ready.
- ready  in  1  memory ready; low inserts a wait state.
- address  out  ADDR_WIDTH  memory address, decoded from flops.
- rd_en  out  1  read request.
- opcode  out  8  current opcode.
- oper_lo / oper_hi  out  8 / 8  operand bytes; unused bytes are 0.
- instr_len  out  2  instruction length in bytes, 1..3.
- instr_valid  out  1  instruction held for execute.
- exec_done  in  1  execute accepts/completes the instruction.
- pc_load  in  1  redirect request, sampled only with exec_done.
- pc_load_value  in  ADDR_WIDTH  redirect target.
- illegal  out  1  unrecognised opcode fetched.
- debug_state  out  8  one-hot state vector.
- debug_PC  out  ADDR_WIDTH  current PC.

## Operation
- States are one-hot: RESET, VEC_LO, VEC_HI, FETCH, OPER1, OPER2, ISSUE, HALT.
- Reset values:
  - state = RESET; PC = 0; opcode, oper_lo, oper_hi = 0; instr_len = 0.
  - instr_valid = 0, rd_en = 0, illegal = 0, address = 0.
- RESET moves to VEC_LO unconditionally one cycle after resetn rises.
- VEC_LO: address = RESET_VECTOR, rd_en = 1. On ready: PC[7:0] ← read_data and PC[ADDR_WIDTH-1:16] ← 0; go to VEC_HI.
- VEC_HI: address = RESET_VECTOR+1, rd_en = 1. On ready: PC[15:8] ← read_data; go to FETCH.
- FETCH: address = PC, rd_en = 1. On ready:
  - opcode ← read_data, PC ← PC+1, oper_lo/oper_hi ← 0, instr_len from the decode table.
  - Length 1 goes to ISSUE; otherwise go to OPER1.
- OPER1: address = PC, rd_en = 1. On ready: oper_lo ← read_data, PC ← PC+1. Length 3 goes to OPER2, otherwise ISSUE.
- OPER2: same as OPER1, into oper_hi; then go to ISSUE.
- ISSUE: instr_valid = 1, rd_en = 0; opcode and operands are held stable. On exec_done: PC ← pc_load ? pc_load_value : PC; go to FETCH.
- Decode table:
  - Length 1: EA NOP, E8 INX, CA DEX, AA TAX, 60 RTS.
  - Length 2: A9 LDA#, A2 LDX#, A5 LDA zp, 85 STA zp, D0 BNE, F0 BEQ.
  - Length 3: 4C JMP, 6C JMP ind, 20 JSR, AD LDA abs, 8D STA abs.
  - Any other opcode is illegal (see Configuration).
- PC arithmetic is modulo 2^ADDR_WIDTH; FFFF+1 wraps to 0000 for the default width.
- exec_done outside ISSUE is ignored. pc_load without exec_done is ignored.
- Asserting resetn low in any state returns immediately to reset values. An in-flight read is abandoned.

## Timing
- Every memory state holds its address and rd_en while ready = 0. No PC, register, or state change occurs during a wait state.
- Zero-wait minimum latencies:
  - resetn high to first FETCH: 3 cycles (RESET, VEC_LO, VEC_HI).
  - Length 1 instruction: 2 cycles (FETCH, ISSUE with exec_done).
  - Length 2 instruction: 3 cycles. Length 3 instruction: 4 cycles.
- instr_valid rises on the cycle after the last byte is read. It falls on the cycle after exec_done is sampled.
- A pc_load redirect takes effect in the very next FETCH address; there is no extra bubble.
- Each wait state adds exactly one cycle to the state it occurs in.

## Configuration
- Macro: FETCH_SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode sets illegal = 1 and moves to HALT; rd_en = 0, instr_valid = 0.
  - HALT holds until reset; exec_done and pc_load are ignored.
- Undefined:
  - An illegal opcode is treated as length 1 and issued normally.
  - illegal pulses high for the one FETCH-completion cycle only.
  - The HALT state still exists in debug_state but is unreachable.

## Test plan
- Reset vector: memory FFFC=00, FFFD=80, ready=1, release reset → address sequence FFFC, FFFD, 8000; debug_PC=8000 on cycle 3.
- NOP stream: 8000..8002=EA, exec_done tied high → instr_valid every 2nd cycle, instr_len=1, PC 8001, 8002, 8003.
- JMP: 8000=4C 34 12, exec_done with pc_load=1, pc_load_value=1234 → oper_lo=34, oper_hi=12, instr_len=3, next FETCH address=1234, 4-cycle instruction.
- Wait states: ready=0 for 3 cycles during OPER1 of A9 55 → address held at 8001, PC unchanged; oper_lo=55 after ready; total 6 cycles to exec_done.
- PC wrap and handshake: FFFF=EA, exec_done delayed 5 cycles → opcode and instr_valid stable for 5 cycles; next FETCH address=0000.
- Illegal and reset: fetch 02 → with the macro, illegal=1 and HALT, no further rd_en; without it, one-cycle illegal pulse and issue as length 1. Assert resetn low in OPER2 → all outputs 0 in the same cycle; restart at VEC_LO.
